// File: rtl/bus_grant_scheduler_if.sv
// Bus grant scheduler interface: request/release/activity lines from the
// masters and slave, plus the registered grant and watchdog status.
// The master modport is the requester/bench side, the slave modport is the
// scheduler side.
interface bus_grant_scheduler_if #(
   parameter int NUM_MASTERS = 4
);
   localparam int ID_W = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] done;
   logic                   ack;
   logic [NUM_MASTERS-1:0] grant;
   logic [ID_W-1:0]        grant_id;
   logic                   busy;
   logic                   timeout;
   logic [ID_W-1:0]        timeout_id;

   modport master (
      output req, done, ack,
      input  grant, grant_id, busy, timeout, timeout_id
   );

   modport slave (
      input  req, done, ack,
      output grant, grant_id, busy, timeout, timeout_id
   );
endinterface

// File: rtl/bus_grant_scheduler.sv
// Round-robin bus grant scheduler with a one-cycle turnaround between grants.
// Optional inactivity watchdog enabled by defining BUS_GRANT_TIMEOUT_EN: the
// count is cleared by slave ack and a grant is revoked (with a one-cycle
// timeout pulse) once the count exceeds TIMEOUT. Without the macro a grant
// ends only on release, ack is unused and timeout/timeout_id are tied to 0.
module bus_grant_scheduler #(
   parameter int NUM_MASTERS = 4,
   parameter int TIMEOUT     = 1000
) (
   input logic                 clk,
   input logic                 rstN,
   bus_grant_scheduler_if.slave bus
);
   localparam int ID_W = $clog2(NUM_MASTERS);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANTED    = 2'd1,
      TURNAROUND = 2'd2
   } state_t;

   state_t                 state;
   logic [ID_W-1:0]        ptr;
   logic                   win_found;
   logic [ID_W-1:0]        win_id;
   logic [NUM_MASTERS-1:0] win_onehot;
   logic                   release_now;
   int                     idx;

`ifdef BUS_GRANT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
   logic [CNT_W-1:0] cnt;
   logic             expired;
   assign expired = (cnt > TO_LIM);
`else
   logic unused_ack;
   assign unused_ack     = bus.ack;
   assign bus.timeout    = 1'b0;
   assign bus.timeout_id = '0;
`endif

   // Round-robin search: first requester above the pointer, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(ptr) + i) % NUM_MASTERS;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = idx[ID_W-1:0];
         end
      end
   end

   assign win_onehot  = NUM_MASTERS'(1) << win_id;
   assign release_now = bus.done[bus.grant_id] | ~bus.req[bus.grant_id];

   // Grant FSM with registered outputs; IDLE and TURNAROUND arbitrate alike.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state        <= IDLE;
         bus.grant    <= '0;
         bus.grant_id <= '0;
         bus.busy     <= 1'b0;
         ptr          <= ID_W'(NUM_MASTERS - 1);
`ifdef BUS_GRANT_TIMEOUT_EN
         bus.timeout    <= 1'b0;
         bus.timeout_id <= '0;
         cnt            <= '0;
`endif
      end else begin
`ifdef BUS_GRANT_TIMEOUT_EN
         bus.timeout <= 1'b0;
`endif
         case (state)
            IDLE, TURNAROUND: begin
               if (win_found) begin
                  bus.grant    <= win_onehot;
                  bus.grant_id <= win_id;
                  bus.busy     <= 1'b1;
                  ptr          <= win_id;
`ifdef BUS_GRANT_TIMEOUT_EN
                  cnt          <= '0;
`endif
                  state        <= GRANTED;
               end else begin
                  state <= IDLE;
               end
            end
            GRANTED: begin
               if (release_now) begin
                  bus.grant    <= '0;
                  bus.grant_id <= '0;
                  bus.busy     <= 1'b0;
                  state        <= TURNAROUND;
               end
`ifdef BUS_GRANT_TIMEOUT_EN
               else if (expired) begin
                  bus.grant      <= '0;
                  bus.grant_id   <= '0;
                  bus.busy       <= 1'b0;
                  bus.timeout    <= 1'b1;
                  bus.timeout_id <= bus.grant_id;
                  state          <= TURNAROUND;
               end else begin
                  cnt <= bus.ack ? '0 : cnt + CNT_W'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Directed bench for bus_grant_scheduler (NUM_MASTERS=4, TIMEOUT=10).
// Each step drives inputs, queues the expected post-edge outputs and checks
// them #1 after the edge. Expectations follow BUS_GRANT_TIMEOUT_EN.
module tb_bus_grant_scheduler;
   localparam int N  = 4;
   localparam int TO = 10;
`ifdef BUS_GRANT_TIMEOUT_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] g;
      logic       t;
      logic [1:0] tid;
   } exp_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   checks = 0;
   int   passed = 0;
   exp_t exp_q[$];
   logic [1:0] tid_exp = 2'd0;

   bus_grant_scheduler_if #(.NUM_MASTERS(N)) bus ();

   bus_grant_scheduler #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rstN(rstN),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] id_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) begin
         passed++;
      end else begin
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] d, input logic a,
                       input logic [3:0] eg, input logic et, input string tag);
      exp_t e;
      bus.req  = r;
      bus.done = d;
      bus.ack  = a;
      exp_q.push_back('{g: eg, t: et, tid: tid_exp});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, " grant"},      8'(bus.grant),      8'(e.g));
      chk({tag, " grant_id"},   8'(bus.grant_id),   8'(id_of(e.g)));
      chk({tag, " busy"},       8'(bus.busy),       8'(|e.g));
      chk({tag, " timeout"},    8'(bus.timeout),    8'(e.t));
      chk({tag, " timeout_id"}, 8'(bus.timeout_id), 8'(e.tid));
   endtask

   initial begin
      #100000;
      $display("FAIL time limit: run did not complete, got timeout expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      bus.req  = '0;
      bus.done = '0;
      bus.ack  = 1'b0;

      // reset state
      rstN = 1'b0;
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "reset");
      rstN = 1'b1;
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "idle");

      // single request, 1-cycle latency, release via done
      step(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, "t1 grant");
      step(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "t1 release");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t1 idle");

      // fresh reset, then full rotation 0,1,2,3,0 with one gap cycle each
      rstN = 1'b0;
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t2 reset");
      rstN = 1'b1;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (k % 4);
         step(4'b1111, 4'b0000, 1'b0, oh, 1'b0, $sformatf("t2 arb%0d", k));
         step(4'b1111, 4'b0000, 1'b0, oh, 1'b0, $sformatf("t2 hold%0da", k));
         step(4'b1111, 4'b0000, 1'b0, oh, 1'b0, $sformatf("t2 hold%0db", k));
         step(4'b1111, oh,      1'b0, 4'b0000, 1'b0, $sformatf("t2 gap%0d", k));
      end
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t2 idle");

      // watchdog expiry on master 2: grant high TO+2 cycles then one pulse
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, "t3 arb");
      for (int i = 0; i < TO + 1; i++)
         step(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, $sformatf("t3 hold%0d", i));
      if (WD) tid_exp = 2'd2;
      step(4'b0100, 4'b0000, 1'b0, WD ? 4'b0000 : 4'b0100, WD, "t3 expire");
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, "t3 regrant");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t3 drop");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t3 idle");

      // periodic ack keeps master 3 granted for 100 cycles
      step(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, "t4 arb");
      for (int i = 0; i < 100; i++)
         step(4'b1000, 4'b0000, (i % 8) == 7, 4'b1000, 1'b0, $sformatf("t4 hold%0d", i));
      step(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0, "t4 release");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t4 idle");

      // release coinciding with expiry: release wins, no pulse
      step(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, "t5 arb");
      for (int i = 0; i < TO + 1; i++)
         step(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, $sformatf("t5 hold%0d", i));
      step(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "t5 release");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t5 idle");

      // reset mid-grant, then rearbitration from master 0 upward
      step(4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0, "t6 arb");
      step(4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0, "t6 hold");
      rstN = 1'b0;
      tid_exp = 2'd0;
      step(4'b1010, 4'b0000, 1'b0, 4'b0000, 1'b0, "t6 reset");
      rstN = 1'b1;
      step(4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0, "t6 regrant");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "t6 drop");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
